// File: rtl/cam_pkg.sv
// Shared types for the CAM request controller: request opcodes and FSM states.
package cam_pkg;

    typedef enum logic [1:0] {
        LOOKUP = 2'd0,
        INSERT = 2'd1,
        DELETE = 2'd2,
        RSVD   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEARCH = 3'd1,
        EVAL   = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } state_e;

endpackage

// File: rtl/priority_encoder.sv
// Lowest-set-bit priority encoder; found is low when no request bit is set.
module priority_encoder #(
    parameter int WIDTH       = 32,
    parameter int INDEX_WIDTH = 5
) (
    input  logic [WIDTH-1:0]       req,
    output logic [INDEX_WIDTH-1:0] index,
    output logic                   found
);

    // NOTE: both outputs get a default before the loop so no latch is inferred.
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = INDEX_WIDTH'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_ctrl.sv
// Request controller for an external CAM: serialises LOOKUP/INSERT/DELETE into
// search/write strobes and tracks entry validity, occupancy and round-robin eviction.
module cam_ctrl
    import cam_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int HEIGHT     = 2 ** ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_op_i,
    input  logic [WIDTH-1:0]      req_key_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_hit_o,
    output logic [ADDR_WIDTH-1:0] rsp_index_o,
    output logic                  rsp_evict_o,
    output logic                  rsp_err_o,
    output logic [ADDR_WIDTH:0]   occupancy_o,
    output logic                  cam_search_enable_o,
    output logic [WIDTH-1:0]      cam_search_data_o,
    input  logic                  cam_search_valid_i,
    input  logic [ADDR_WIDTH-1:0] cam_search_index_i,
    output logic                  cam_write_enable_o,
    output logic [ADDR_WIDTH-1:0] cam_write_index_o,
    output logic [WIDTH-1:0]      cam_write_data_o
);

    state_e                state_q, state_d;
    op_e                   op_q;
    logic [WIDTH-1:0]      key_q;
    logic [HEIGHT-1:0]     valid_q;
    logic [ADDR_WIDTH-1:0] rr_q;
    logic [ADDR_WIDTH:0]   occ_q;
    logic                  ready_q;
    logic                  rsp_hit_q, rsp_evict_q, rsp_err_q;
    logic [ADDR_WIDTH-1:0] rsp_index_q;

    logic                  accept, hit, stale;
    logic [HEIGHT-1:0]     free_vec;
    logic [ADDR_WIDTH-1:0] free_idx, ins_target;
    logic                  free_found, ins_evict;

    assign free_vec = ~valid_q;

    priority_encoder #(
        .WIDTH       (HEIGHT),
        .INDEX_WIDTH (ADDR_WIDTH)
    ) u_free_slot (
        .req   (free_vec),
        .index (free_idx),
        .found (free_found)
    );

    // A CAM match on an entry we have invalidated is stale and may be recycled.
    assign accept     = req_valid_i & req_ready_o;
    assign hit        = cam_search_valid_i & valid_q[cam_search_index_i];
    assign stale      = cam_search_valid_i & ~valid_q[cam_search_index_i];
    assign ins_evict  = ~stale & ~free_found;
    assign ins_target = stale ? cam_search_index_i : (free_found ? free_idx : rr_q);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (op_e'(req_op_i) == RSVD) ? RESP : SEARCH;
            SEARCH:  state_d = EVAL;
            EVAL:    state_d = (op_q == INSERT && !hit) ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every register here uses <= so all updates see pre-edge values of each other.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_q        <= LOOKUP;
            key_q       <= '0;
            valid_q     <= '0;
            rr_q        <= '0;
            occ_q       <= '0;
            ready_q     <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_index_q <= '0;
            rsp_evict_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            occ_q   <= (ADDR_WIDTH + 1)'($countones(valid_q));
            case (state_q)
                IDLE: if (accept) begin
                    op_q        <= op_e'(req_op_i);
                    key_q       <= req_key_i;
                    rsp_hit_q   <= 1'b0;
                    rsp_index_q <= '0;
                    rsp_evict_q <= 1'b0;
                    rsp_err_q   <= (op_e'(req_op_i) == RSVD);
                end
                EVAL: begin
                    rsp_hit_q   <= hit;
                    rsp_index_q <= hit ? cam_search_index_i : '0;
                    if (op_q == DELETE && hit) valid_q[cam_search_index_i] <= 1'b0;
                    if (op_q == INSERT && !hit) begin
                        rsp_index_q <= ins_target;
                        rsp_evict_q <= ins_evict;
                        if (ins_evict) rr_q <= rr_q + 1'b1;
                    end
                end
                WRITE:   valid_q[rsp_index_q] <= 1'b1;
                default: ;
            endcase
        end
    end

    // Outputs are gated by state so nothing leaks outside its phase or during reset.
    assign req_ready_o         = ready_q && (state_q == IDLE);
    assign rsp_valid_o         = (state_q == RESP);
    assign rsp_hit_o           = rsp_valid_o & rsp_hit_q;
    assign rsp_index_o         = rsp_valid_o ? rsp_index_q : '0;
    assign rsp_evict_o         = rsp_valid_o & rsp_evict_q;
    assign rsp_err_o           = rsp_valid_o & rsp_err_q;
    assign occupancy_o         = occ_q;
    assign cam_search_enable_o = (state_q == SEARCH);
    assign cam_search_data_o   = cam_search_enable_o ? key_q : '0;
    assign cam_write_enable_o  = (state_q == WRITE);
    assign cam_write_index_o   = cam_write_enable_o ? rsp_index_q : '0;
    assign cam_write_data_o    = cam_write_enable_o ? key_q : '0;

endmodule

// File: tb/tb_cam_ctrl.sv
// Self-checking bench for cam_ctrl: behavioural CAM responder plus a table-level
// reference model of valid entries, stale reuse and round-robin eviction.
module tb_cam_ctrl;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int H  = 32;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          req_valid_i, req_ready_o;
    logic [1:0]    req_op_i;
    logic [W-1:0]  req_key_i;
    logic          rsp_valid_o, rsp_ready_i;
    logic          rsp_hit_o, rsp_evict_o, rsp_err_o;
    logic [AW-1:0] rsp_index_o;
    logic [AW:0]   occupancy_o;
    logic          cam_search_enable_o, cam_search_valid_i;
    logic [W-1:0]  cam_search_data_o;
    logic [AW-1:0] cam_search_index_i;
    logic          cam_write_enable_o;
    logic [AW-1:0] cam_write_index_o;
    logic [W-1:0]  cam_write_data_o;

    int n_checks = 0;
    int n_fail   = 0;

    cam_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW), .HEIGHT(H)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_key_i(req_key_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_hit_o(rsp_hit_o), .rsp_index_o(rsp_index_o),
        .rsp_evict_o(rsp_evict_o), .rsp_err_o(rsp_err_o),
        .occupancy_o(occupancy_o),
        .cam_search_enable_o(cam_search_enable_o), .cam_search_data_o(cam_search_data_o),
        .cam_search_valid_i(cam_search_valid_i), .cam_search_index_i(cam_search_index_i),
        .cam_write_enable_o(cam_write_enable_o), .cam_write_index_o(cam_write_index_o),
        .cam_write_data_o(cam_write_data_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural CAM: contents survive controller reset; search answers one cycle later.
    logic [W-1:0] cam_mem  [H];
    bit           cam_used [H];
    int           search_cnt = 0, write_cnt = 0, strobe_viol = 0;
    logic [AW-1:0] last_w_idx;
    logic [W-1:0]  last_w_data;

    function automatic int cam_find(input logic [W-1:0] k);
        for (int i = 0; i < H; i++) if (cam_used[i] && cam_mem[i] == k) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (cam_search_enable_o) begin
            search_cnt         <= search_cnt + 1;
            cam_search_valid_i <= (cam_find(cam_search_data_o) >= 0);
            cam_search_index_i <= (cam_find(cam_search_data_o) >= 0) ? AW'(cam_find(cam_search_data_o)) : '0;
        end else begin
            cam_search_valid_i <= 1'b0;
            cam_search_index_i <= '0;
        end
        if (cam_write_enable_o) begin
            write_cnt                  <= write_cnt + 1;
            cam_mem[cam_write_index_o]  <= cam_write_data_o;
            cam_used[cam_write_index_o] <= 1'b1;
            last_w_idx                 <= cam_write_index_o;
            last_w_data                <= cam_write_data_o;
        end
    end

    always @(negedge clk) begin
        if (cam_search_enable_o && cam_write_enable_o) strobe_viol++;
        if (!cam_search_enable_o && cam_search_data_o != '0) strobe_viol++;
        if (!cam_write_enable_o && (cam_write_index_o != '0 || cam_write_data_o != '0)) strobe_viol++;
    end

    // Reference model: which keys are live, what each slot last held, eviction pointer.
    logic [W-1:0] ref_key   [H];
    bit           ref_known [H];
    bit           ref_valid [H];
    int           ref_rr;

    function automatic int ref_count();
        int c = 0;
        for (int i = 0; i < H; i++) c += int'(ref_valid[i]);
        return c;
    endfunction

    task automatic model(input logic [1:0] op, input logic [W-1:0] key,
                         output bit hit, output int idx, output bit evict,
                         output bit err, output bit wr);
        int m = -1;
        int free = -1;
        hit = 0; idx = 0; evict = 0; err = 0; wr = 0;
        if (op == 2'd3) begin
            err = 1;
            return;
        end
        for (int i = H - 1; i >= 0; i--) if (ref_known[i] && ref_key[i] == key) m = i;
        hit = (m >= 0) && ref_valid[m];
        if (hit) idx = m;
        if (op == 2'd2 && hit) ref_valid[m] = 0;
        if (op == 2'd1 && !hit) begin
            for (int i = H - 1; i >= 0; i--) if (!ref_valid[i]) free = i;
            if (m >= 0)         idx = m;
            else if (free >= 0) idx = free;
            else begin
                idx    = ref_rr;
                evict  = 1;
                ref_rr = (ref_rr + 1) % H;
            end
            ref_key[idx] = key; ref_known[idx] = 1; ref_valid[idx] = 1; wr = 1;
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] key, input int hold);
        bit e_hit, e_evict, e_err, e_wr;
        int e_idx, e_lat, s0, w0, n;
        model(op, key, e_hit, e_idx, e_evict, e_err, e_wr);
        e_lat = e_err ? 1 : (e_wr ? 4 : 3);
        s0 = search_cnt; w0 = write_cnt;
        @(negedge clk);
        req_valid_i = 1'b1; req_op_i = op; req_key_i = key;
        n = 0;
        while (req_ready_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            check("accept_timeout", 0, 1);
            req_valid_i = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid_i = 1'b0; req_key_i = $urandom();
        n = 1;
        while (rsp_valid_o !== 1'b1 && n < 12) begin @(negedge clk); n++; end
        check("latency", 64'(n), 64'(e_lat));
        if (rsp_valid_o !== 1'b1) return;
        for (int c = 0; c <= hold; c++) begin
            check("rsp_hit", rsp_hit_o, e_hit);
            check("rsp_index", rsp_index_o, 64'(e_idx));
            check("rsp_evict", rsp_evict_o, e_evict);
            check("rsp_err", rsp_err_o, e_err);
            check("ready_in_resp", req_ready_o, 0);
            if (c < hold) @(negedge clk);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        check("rsp_valid_drop", rsp_valid_o, 0);
        check("search_strobes", 64'(search_cnt - s0), e_err ? 0 : 1);
        check("write_strobes", 64'(write_cnt - w0), e_wr ? 1 : 0);
        if (e_wr) begin
            check("write_index", last_w_idx, 64'(e_idx));
            check("write_data", last_w_data, key);
        end
        check("occupancy", occupancy_o, 64'(ref_count()));
    endtask

    task automatic reset_model();
        for (int i = 0; i < H; i++) ref_valid[i] = 0;
        ref_rr = 0;
    endtask

    task automatic reset_during_write(input logic [W-1:0] key);
        int n, w0;
        @(negedge clk);
        req_valid_i = 1'b1; req_op_i = 2'd1; req_key_i = key;
        @(negedge clk);
        req_valid_i = 1'b0;
        n = 0;
        while (cam_write_enable_o !== 1'b1 && n < 8) begin @(negedge clk); n++; end
        check("write_phase_seen", cam_write_enable_o, 1);
        w0 = write_cnt;
        rst_i = 1'b0;
        #1;
        check("rst_kills_write", cam_write_enable_o, 0);
        check("rst_no_rsp", rsp_valid_o, 0);
        check("rst_occupancy", occupancy_o, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_ready_low", req_ready_o, 0);
            check("rst_no_rsp_hold", rsp_valid_o, 0);
        end
        rst_i = 1'b1;
        @(negedge clk);
        check("ready_after_rst", req_ready_o, 1);
        check("no_write_after_rst", 64'(write_cnt - w0), 0);
        check("occ_after_rst", occupancy_o, 0);
        reset_model();
    endtask

    logic [W-1:0] pool [40];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0; req_valid_i = 1'b0; req_op_i = '0; req_key_i = '0; rsp_ready_i = 1'b0;
        cam_search_valid_i = 1'b0; cam_search_index_i = '0;
        for (int i = 0; i < H; i++) begin
            cam_used[i] = 0; cam_mem[i] = '0; ref_known[i] = 0; ref_key[i] = '0;
        end
        reset_model();
        for (int i = 0; i < 40; i++) pool[i] = {8'hC3, 24'($urandom())};

        repeat (3) @(negedge clk);
        check("reset_ready", req_ready_o, 0);
        check("reset_rsp_valid", rsp_valid_o, 0);
        check("reset_occupancy", occupancy_o, 0);
        check("reset_strobes", {cam_search_enable_o, cam_write_enable_o}, 0);
        rst_i = 1'b1;
        @(negedge clk);
        check("ready_rises", req_ready_o, 1);

        send(2'd1, 32'hDEAD_BEEF, 0);          // first insert -> slot 0, latency 4
        send(2'd1, 32'hDEAD_BEEF, 0);          // duplicate insert -> hit, no write
        send(2'd2, 32'hDEAD_BEEF, 0);          // delete -> hit, occupancy 0
        send(2'd0, 32'hDEAD_BEEF, 0);          // lookup of deleted key -> miss
        send(2'd1, 32'hDEAD_BEEF, 0);          // stale reuse of slot 0

        for (int i = 1; i < H; i++) send(2'd1, 32'h1000_0000 + 32'(i), 0);
        send(2'd1, 32'h2000_0001, 0);          // full table -> evict slot 0
        send(2'd1, 32'h2000_0002, 0);          // full table -> evict slot 1
        check("full_occupancy", occupancy_o, 32);

        send(2'd0, 32'h1000_0005, 5);          // stalled response stays stable
        send(2'd3, 32'h1234_5678, 5);          // reserved op

        for (int t = 0; t < 80; t++) begin
            logic [1:0] op;
            op = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            send(op, pool[$urandom_range(0, 39)], $urandom_range(0, 2));
        end

        reset_during_write(32'hBAD0_0001);
        send(2'd0, 32'h1000_0007, 0);          // contents now stale after reset
        for (int t = 0; t < 20; t++)
            send(2'($urandom_range(0, 2)), pool[$urandom_range(0, 39)], 0);

        check("strobe_rules", 64'(strobe_viol), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_ctrl.md
CAM_CTRL -- requirements
Module: cam_ctrl

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, key width; ADDR_WIDTH, 5, entry index width; HEIGHT, 32, entry count (2**ADDR_WIDTH).
REQ-002 Ports SHALL be (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock
- rst_i  in  1  async active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_op_i  in  2  0=LOOKUP, 1=INSERT, 2=DELETE, 3=reserved
- req_key_i  in  WIDTH  key
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_hit_o  out  1  key present and valid before op
- rsp_index_o  out  ADDR_WIDTH  entry index
- rsp_evict_o  out  1  INSERT replaced a valid entry
- rsp_err_o  out  1  reserved op
- occupancy_o  out  ADDR_WIDTH+1  count of valid entries
- cam_search_enable_o  out  1  CAM search strobe
- cam_search_data_o  out  WIDTH  search key
- cam_search_valid_i  in  1  CAM match found
- cam_search_index_i  in  ADDR_WIDTH  lowest matching index
- cam_write_enable_o  out  1  CAM write strobe
- cam_write_index_o  out  ADDR_WIDTH  write index
- cam_write_data_o  out  WIDTH  write key

Function
REQ-003 Block SHALL be the initiator driving the CAM search/write ports; it SHALL keep a HEIGHT-bit valid bitmap valid_q and treat any CAM match at an index with valid_q=0 as stale.
REQ-004 FSM states SHALL be IDLE, SEARCH, EVAL, WRITE, RESP; req_ready_o=1 only in IDLE.
REQ-005 IDLE: on req_valid_i&req_ready_o, latch op and key -> SEARCH; reserved op -> RESP with rsp_err_o=1, no CAM access.
REQ-006 SEARCH: assert cam_search_enable_o for exactly one cycle with cam_search_data_o=key -> EVAL.
REQ-007 EVAL: sample cam_search_valid_i/cam_search_index_i (CAM search latency is exactly one cycle); hit = cam_search_valid_i & valid_q[index].
REQ-008 LOOKUP: -> RESP; rsp_hit_o=hit, rsp_index_o=match index if hit, else 0.
REQ-009 DELETE: if hit, clear valid_q[index] in EVAL; -> RESP with rsp_hit_o=hit.
REQ-010 INSERT with hit: no write; -> RESP, rsp_hit_o=1, rsp_index_o=match index.
REQ-011 INSERT with stale match: target = stale index; INSERT with no match: target = lowest index with valid_q=0; if all valid, target = rr_q, rsp_evict_o=1, rr_q increments modulo HEIGHT.
REQ-012 WRITE: assert cam_write_enable_o for one cycle at target with key; set valid_q[target] -> RESP, rsp_index_o=target.
REQ-013 RESP: hold rsp_valid_o and all rsp_* stable until rsp_ready_i; then -> IDLE. Next request is accepted no earlier than the following cycle.
REQ-014 Latency from accept to rsp_valid_o SHALL be 3 cycles without write and 4 cycles with write.
REQ-015 cam_search_enable_o and cam_write_enable_o SHALL never be asserted in the same cycle; outside their states both SHALL be 0 and their data/index outputs SHALL be 0.
REQ-016 occupancy_o SHALL equal popcount(valid_q), registered, updated the cycle after valid_q changes; range 0..HEIGHT.
REQ-017 The block SHALL hold the invariant that no key is stored at more than one index with valid_q=1.

Reset
REQ-018 While rst_i=0: state=IDLE, valid_q=0, rr_q=0, occupancy_o=0, all outputs 0 except req_ready_o=0; req_ready_o SHALL rise in the first cycle after deassertion.
REQ-019 Reset mid-operation SHALL abort the operation with no response and no further CAM strobe.

Structure
REQ-020 cam_pkg SHALL hold the op enum (LOOKUP, INSERT, DELETE, RSVD) and the state enum; cam_ctrl SHALL import it.
REQ-021 Free-slot search SHALL instantiate the existing priority_encoder on ~valid_q; no other sub-module.

Verification
REQ-022 Empty table, INSERT key 0xDEADBEEF -> write at index 0, rsp_hit=0, rsp_index=0, occupancy=1, response at cycle 4.
REQ-023 Repeat INSERT 0xDEADBEEF -> no CAM write, rsp_hit=1, rsp_index=0, occupancy stays 1.
REQ-024 DELETE 0xDEADBEEF, then LOOKUP it -> delete hit=1 and occupancy=0; lookup rsp_hit=0; re-INSERT writes index 0 (stale reuse).
REQ-025 Fill 32 distinct keys, INSERT a 33rd twice -> indices 0 then 1, rsp_evict=1 both times, occupancy=32.
REQ-026 Hold rsp_ready_i=0 for 5 cycles -> rsp_* stable, req_ready_o=0; op 3 -> rsp_err=1 with no CAM strobe.
REQ-027 Assert rst_i=0 during WRITE -> no write strobe afterwards, valid_q=0, no response.
